// File: rtl/qracc_job_sequencer.sv
// Job sequencer for the QR accelerator: walks every tile through
// weight load, row issue, pipeline drain and writeback after a CSR start.
module qracc_job_sequencer #(
  parameter int TILE_W     = 8,
  parameter int ROW_W      = 10,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [TILE_W-1:0] cfg_tiles_i,
  input  logic [ROW_W-1:0]  cfg_rows_i,
  output logic              load_req_o,
  input  logic              load_ack_i,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic [ROW_W-1:0]  row_idx_o,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              wb_req_o,
  input  logic              wb_ack_i,
  output logic              busy_o,
  output logic              done_pulse_o,
  output logic              acc_done_o,
  output logic              cfg_err_o
);

  localparam int DW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    WB      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [TILE_W-1:0] tiles_reg;
  logic [ROW_W-1:0]  rows_reg;
  logic [TILE_W-1:0] tile_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [DW-1:0]     drain_reg;
  logic              acc_done_reg;
  logic              cfg_err_reg;

  logic [TILE_W-1:0] tiles_m1;
  logic [ROW_W-1:0]  rows_m1;
  logic              last_row;
  logic              last_tile;
  logic              start_ok;
  logic              cfg_zero;

  assign tiles_m1  = tiles_reg - 1'b1;
  assign rows_m1   = rows_reg - 1'b1;
  assign last_row  = (row_reg == rows_m1);
  assign last_tile = (tile_reg == tiles_m1);
  // Abort outranks start, so a start coincident with abort is simply lost.
  assign start_ok  = (state_reg == IDLE) && start_i && !abort_i;
  assign cfg_zero  = (cfg_tiles_i == '0) || (cfg_rows_i == '0);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i && !cfg_zero) begin
            state_next = LOAD;
          end
        end
        LOAD: begin
          if (load_ack_i) begin
            state_next = COMPUTE;
          end
        end
        COMPUTE: begin
          if (row_ready_i && last_row) begin
            state_next = (PIPE_DEPTH == 0) ? WB : DRAIN;
          end
        end
        DRAIN: begin
          if (drain_reg == '0) begin
            state_next = WB;
          end
        end
        WB: begin
          if (wb_ack_i) begin
            state_next = last_tile ? DONE : LOAD;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      tiles_reg <= '0;
      rows_reg  <= '0;
      tile_reg  <= '0;
      row_reg   <= '0;
      drain_reg <= '0;
    end else if (abort_i) begin
      tile_reg  <= '0;
      row_reg   <= '0;
      drain_reg <= '0;
    end else begin
      if (start_ok) begin
        tiles_reg <= cfg_tiles_i;
        rows_reg  <= cfg_rows_i;
        tile_reg  <= '0;
        row_reg   <= '0;
      end
      if (state_reg == COMPUTE && row_ready_i && !last_row) begin
        row_reg <= row_reg + 1'b1;
      end
      // Counter is preloaded as COMPUTE hands over, so DRAIN spans PIPE_DEPTH cycles.
      if (state_reg == COMPUTE && state_next == DRAIN) begin
        drain_reg <= DRAIN_INIT;
      end else if (state_reg == DRAIN && drain_reg != '0) begin
        drain_reg <= drain_reg - 1'b1;
      end
      if (state_reg == WB && wb_ack_i && !last_tile) begin
        tile_reg <= tile_reg + 1'b1;
        row_reg  <= '0;
      end
      if (state_reg == DONE) begin
        tile_reg <= '0;
        row_reg  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_done_reg <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else if (start_ok) begin
      // An empty job completes immediately, flagged as a config error.
      acc_done_reg <= cfg_zero;
      cfg_err_reg  <= cfg_zero;
    end else if (state_reg == DONE && !abort_i) begin
      acc_done_reg <= 1'b1;
    end
  end

  assign load_req_o   = (state_reg == LOAD);
  assign row_valid_o  = (state_reg == COMPUTE);
  assign wb_req_o     = (state_reg == WB);
  assign busy_o       = (state_reg != IDLE);
  assign done_pulse_o = (state_reg == DONE);
  assign row_idx_o    = row_reg;
  assign tile_idx_o   = tile_reg;
  assign acc_done_o   = acc_done_reg;
  assign cfg_err_o    = cfg_err_reg;

endmodule

// File: tb/tb_qracc_job_sequencer.sv
// Directed bench for qracc_job_sequencer: single/multi-tile jobs, stalls,
// empty config, abort, start-while-busy and mid-job reset.
module tb_qracc_job_sequencer;

  logic       clk = 1'b0;
  logic       nrst, start_i, abort_i;
  logic [7:0] cfg_tiles_i;
  logic [9:0] cfg_rows_i;
  logic       load_req_o, load_ack_i, row_valid_o, row_ready_i;
  logic [9:0] row_idx_o;
  logic [7:0] tile_idx_o;
  logic       wb_req_o, wb_ack_i, busy_o, done_pulse_o, acc_done_o, cfg_err_o;

  int passes = 0;
  int total  = 0;

  int log_tile [0:255];
  int log_row  [0:255];
  int log_n    = 0;
  int load_hs  = 0;
  int wb_hs    = 0;
  int done_cnt = 0;

  qracc_job_sequencer #(.TILE_W(8), .ROW_W(10), .PIPE_DEPTH(3)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .abort_i(abort_i),
    .cfg_tiles_i(cfg_tiles_i), .cfg_rows_i(cfg_rows_i),
    .load_req_o(load_req_o), .load_ack_i(load_ack_i),
    .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .row_idx_o(row_idx_o), .tile_idx_o(tile_idx_o),
    .wb_req_o(wb_req_o), .wb_ack_i(wb_ack_i), .busy_o(busy_o),
    .done_pulse_o(done_pulse_o), .acc_done_o(acc_done_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  // Handshake monitor: samples pre-edge values at every rising edge.
  always @(posedge clk) begin
    if (row_valid_o && row_ready_i && log_n < 256) begin
      log_tile[log_n] = int'(tile_idx_o);
      log_row[log_n]  = int'(row_idx_o);
      log_n = log_n + 1;
    end
    if (load_req_o && load_ack_i) load_hs = load_hs + 1;
    if (wb_req_o && wb_ack_i) wb_hs = wb_hs + 1;
    if (done_pulse_o) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    for (int i = 0; i < budget && done_cnt == base; i++) tick();
    chk(tag, done_cnt - base, 1);
  endtask

  int b_rows, b_load, b_wb, b_done, ok;

  initial begin
    nrst = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    cfg_tiles_i = '0; cfg_rows_i = '0;
    load_ack_i = 1'b0; row_ready_i = 1'b0; wb_ack_i = 1'b0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_reqs", {load_req_o, row_valid_o, wb_req_o}, 0);
    chk("rst_flags", {done_pulse_o, acc_done_o, cfg_err_o}, 0);
    chk("rst_idx", {tile_idx_o, row_idx_o}, 0);
    nrst = 1'b1;
    tick();

    // 1: single tile, two rows, everything tied ready
    cfg_tiles_i = 8'd1; cfg_rows_i = 10'd2;
    load_ack_i = 1'b1; row_ready_i = 1'b1; wb_ack_i = 1'b1;
    start_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start_i = 1'b0;
      chk($sformatf("t1_load_c%0d", c), load_req_o, (c == 1));
      chk($sformatf("t1_valid_c%0d", c), row_valid_o, (c == 2 || c == 3));
      chk($sformatf("t1_wb_c%0d", c), wb_req_o, (c == 7));
      chk($sformatf("t1_done_c%0d", c), done_pulse_o, (c == 8));
      chk($sformatf("t1_acc_c%0d", c), acc_done_o, (c == 9));
      chk($sformatf("t1_busy_c%0d", c), busy_o, (c <= 8));
      if (c == 2 || c == 3) chk($sformatf("t1_row_c%0d", c), row_idx_o, c - 2);
    end

    // 2: three tiles of four rows under pseudo-random stalls
    b_rows = log_n; b_load = load_hs; b_wb = wb_hs; b_done = done_cnt;
    cfg_tiles_i = 8'd3; cfg_rows_i = 10'd4;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t2_acc_cleared", acc_done_o, 0);
    for (int i = 0; i < 600 && done_cnt == b_done; i++) begin
      load_ack_i  = ($urandom_range(0, 2) == 0);
      row_ready_i = ($urandom_range(0, 1) == 0);
      wb_ack_i    = ($urandom_range(0, 2) == 0);
      tick();
    end
    chk("t2_done_once", done_cnt - b_done, 1);
    chk("t2_rows", log_n - b_rows, 12);
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      if (b_rows + i >= 256 || log_tile[b_rows + i] != i / 4 || log_row[b_rows + i] != i % 4) ok = 0;
    end
    chk("t2_row_order", ok, 1);
    chk("t2_load_hs", load_hs - b_load, 3);
    chk("t2_wb_hs", wb_hs - b_wb, 3);
    load_ack_i = 1'b1; row_ready_i = 1'b1; wb_ack_i = 1'b1;
    tick();
    chk("t2_acc_done", acc_done_o, 1);
    chk("t2_single_pulse", done_cnt - b_done, 1);

    // 3: zero rows is a config error that never leaves IDLE
    cfg_tiles_i = 8'd5; cfg_rows_i = 10'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t3_cfg_err", cfg_err_o, 1);
    chk("t3_acc_done", acc_done_o, 1);
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (busy_o || load_req_o || row_valid_o || wb_req_o || done_pulse_o) ok = 0;
      tick();
    end
    chk("t3_stayed_idle", ok, 1);

    // 4: valid start clears flags; abort at tile 1 row 2
    b_done = done_cnt;
    cfg_tiles_i = 8'd2; cfg_rows_i = 10'd4;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t4_err_cleared", cfg_err_o, 0);
    chk("t4_acc_cleared", acc_done_o, 0);
    chk("t4_load", load_req_o, 1);
    for (int i = 0; i < 100 && !(row_valid_o && tile_idx_o == 8'd1 && row_idx_o == 10'd2); i++) tick();
    chk("t4_reach_t1r2", {tile_idx_o, row_idx_o}, {8'd1, 10'd2});
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t4_abort_idle", busy_o, 0);
    chk("t4_abort_valid", row_valid_o, 0);
    chk("t4_abort_idx", {tile_idx_o, row_idx_o}, 0);
    chk("t4_abort_acc", acc_done_o, 0);
    tick();
    chk("t4_no_pulse", done_cnt - b_done, 0);
    // abort coincident with start in IDLE drops the start
    cfg_tiles_i = 8'd1; cfg_rows_i = 10'd1;
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("t4_abort_beats_start", busy_o, 0);
    b_rows = log_n;
    cfg_tiles_i = 8'd2; cfg_rows_i = 10'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("t4_rerun_done", b_done, 200);
    chk("t4_rerun_rows", log_n - b_rows, 6);
    tick();
    chk("t4_rerun_acc", acc_done_o, 1);

    // 5: start while busy in WB with different config is ignored
    b_rows = log_n; b_done = done_cnt;
    cfg_tiles_i = 8'd2; cfg_rows_i = 10'd2;
    wb_ack_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 50 && !wb_req_o; i++) tick();
    chk("t5_in_wb", wb_req_o, 1);
    cfg_tiles_i = 8'd7; cfg_rows_i = 10'd9;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t5_still_wb", wb_req_o, 1);
    chk("t5_tile0", tile_idx_o, 0);
    wb_ack_i = 1'b1;
    wait_done("t5_done", b_done, 100);
    chk("t5_rows", log_n - b_rows, 4);
    chk("t5_last_tile", log_tile[log_n - 1], 1);

    // 6: reset pulse while in LOAD
    cfg_tiles_i = 8'd1; cfg_rows_i = 10'd1;
    load_ack_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("t6_in_load", load_req_o, 1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t6_outs", {load_req_o, row_valid_o, wb_req_o, busy_o, done_pulse_o}, 0);
    chk("t6_flags", {acc_done_o, cfg_err_o}, 0);
    chk("t6_idx", {tile_idx_o, row_idx_o}, 0);
    load_ack_i = 1'b1;
    tick();
    chk("t6_idle_after", {busy_o, load_req_o}, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
